// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the RV32I core. It keeps an in-order scoreboard of
// issued-but-not-retired destination registers and uses it to stall decode on
// read-after-write hazards. It also freezes the pipeline while memory is busy
// and squashes fetch/decode after a taken branch.
//
// Parameters
//   DEPTH      scoreboard entries, issue to writeback commit (2..7)
//   FLUSH_LEN  cycles FLUSH is high after a taken branch, the branch cycle
//              included (1..7)
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   D_VALID         decode holds a valid instruction
//   D_OPCODE        decoded opcode
//   D_REG_D/S1/S2   rd, rs1, rs2 of the decode instruction
//   MEM_BUSY        memory wait, freezes everything
//   BR_TAKEN        execute resolved a taken branch/jump
//   M_VALID         writeback commit of the oldest in-flight instruction
//   M_REG_D         rd being committed (checked only with the statistics build)
//   HOLD            hold fetch and decode latches
//   FREEZE          freeze all stages, gate regfile write
//   BUBBLE          execute latch loads invalid
//   ISSUE           decode instruction accepted into execute
//   FLUSH           squash fetch/decode contents
//   STATE           FSM state (RUN=0, INTERLOCK=1, FREEZE=2, FLUSH=3)
//   OCC             scoreboard occupancy
//   ERR             sticky commit error
//
// Build option
//   HAZARD_CTRL_STAT_EN  adds STAT_ISSUE, STAT_STALL, STAT_FLUSH counters and
//                        flags a commit whose M_REG_D differs from the head rd.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int DEPTH     = 3,
    parameter int FLUSH_LEN = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_VALID,
    input  logic [6:0]  D_OPCODE,
    input  logic [4:0]  D_REG_D,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        MEM_BUSY,
    input  logic        BR_TAKEN,
    input  logic        M_VALID,
    input  logic [4:0]  M_REG_D,
    output logic        HOLD,
    output logic        FREEZE,
    output logic        BUBBLE,
    output logic        ISSUE,
    output logic        FLUSH,
    output logic [1:0]  STATE,
    output logic [2:0]  OCC,
`ifdef HAZARD_CTRL_STAT_EN
    output logic [31:0] STAT_ISSUE,
    output logic [31:0] STAT_STALL,
    output logic [31:0] STAT_FLUSH,
`endif
    output logic        ERR
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_INTERLOCK = 2'd1,
        ST_FREEZE    = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    // Operand usage of an opcode, returned as {uses_rs1, uses_rs2, writes_rd}.
    function automatic logic [2:0] op_uses(input logic [6:0] op);
        logic [2:0] u;
        case (op)
            7'b0110011:                         u = 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: u = 3'b101;
            7'b0100011, 7'b1100011:             u = 3'b110;
            7'b0110111, 7'b0010111, 7'b1101111: u = 3'b001;
            default:                            u = 3'b000;
        endcase
        return u;
    endfunction

    state_t     state_r;
    logic [2:0] occ_r;
    logic [2:0] cnt_r;
    logic       err_r;
    logic [4:0] sb_rd_r [DEPTH];

    logic [2:0] uses_s;
    logic       haz_s;
    logic       pop_s;
    logic       pop_eff_s;
    logic       full_s;
    logic       flushing_s;
    logic       hold_s;
    logic       freeze_s;
    logic       issue_s;
    logic       flush_s;
    logic       br_acc_s;
    logic       stall_s;
    logic [4:0] push_rd_s;
    logic [2:0] wr_idx_s;

`ifndef HAZARD_CTRL_STAT_EN
    logic unused_m_reg_d;
    assign unused_m_reg_d = ^M_REG_D;
`endif

    // Hazard detection against every live entry, the retiring head included,
    // because its regfile write only lands at the coming edge.
    always_comb begin
        uses_s = op_uses(D_OPCODE);
        haz_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            haz_s = haz_s | ((3'(i) < occ_r) &&
                    ((uses_s[2] && (D_REG_S1 != 5'd0) && (sb_rd_r[i] == D_REG_S1)) ||
                     (uses_s[1] && (D_REG_S2 != 5'd0) && (sb_rd_r[i] == D_REG_S2))));
        end
        haz_s = haz_s & D_VALID;
    end

    // Per-cycle control decision in priority order:
    // memory wait > taken branch > flush countdown > hazard/full > issue.
    always_comb begin
        pop_s      = M_VALID & ~MEM_BUSY;
        pop_eff_s  = pop_s & (occ_r != 3'd0);
        full_s     = D_VALID & (occ_r == 3'(DEPTH)) & ~pop_s;
        // The counter is non-zero exactly while FLUSH-state cycles remain,
        // which also lets a flush resume after an intervening freeze.
        flushing_s = (cnt_r != 3'd0);
        hold_s     = 1'b0;
        freeze_s   = 1'b0;
        issue_s    = 1'b0;
        flush_s    = 1'b0;
        br_acc_s   = 1'b0;
        stall_s    = 1'b0;
        if (RST) begin
            hold_s = 1'b0;
        end else if (MEM_BUSY) begin
            freeze_s = 1'b1;
            hold_s   = 1'b1;
        end else if (BR_TAKEN) begin
            flush_s  = 1'b1;
            br_acc_s = 1'b1;
        end else if (flushing_s) begin
            flush_s = 1'b1;
        end else if (haz_s || full_s) begin
            hold_s  = 1'b1;
            stall_s = 1'b1;
        end else begin
            issue_s = D_VALID;
        end
        // Every issue takes an entry; non-writers record x0 so they never match.
        push_rd_s = uses_s[0] ? D_REG_D : 5'd0;
        // A same-cycle pop shifts the FIFO down, so the tail slot moves too.
        wr_idx_s  = pop_eff_s ? (occ_r - 3'd1) : occ_r;
    end

    assign HOLD   = hold_s;
    assign FREEZE = freeze_s;
    assign ISSUE  = issue_s;
    assign BUBBLE = ~issue_s;
    assign FLUSH  = flush_s;
    assign STATE  = state_r;
    assign OCC    = occ_r;
    assign ERR    = err_r;

    // Sequencer FSM, flush counter, scoreboard FIFO and sticky error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_RUN;
            occ_r   <= 3'd0;
            cnt_r   <= 3'd0;
            err_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sb_rd_r[i] <= 5'd0;
            end
        end else begin
            if (MEM_BUSY) begin
                state_r <= ST_FREEZE;
            end else if (BR_TAKEN) begin
                state_r <= (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;
                cnt_r   <= 3'(FLUSH_LEN - 1);
            end else if (flushing_s) begin
                state_r <= (cnt_r > 3'd1) ? ST_FLUSH : ST_RUN;
                cnt_r   <= cnt_r - 3'd1;
            end else if (stall_s) begin
                state_r <= ST_INTERLOCK;
            end else begin
                state_r <= ST_RUN;
            end

            // Shift out the head on a commit; the new entry lands at the tail.
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (issue_s && (wr_idx_s == 3'(i))) begin
                    sb_rd_r[i] <= push_rd_s;
                end else if (pop_eff_s) begin
                    sb_rd_r[i] <= sb_rd_r[i + 1];
                end
            end
            if (issue_s && (wr_idx_s == 3'(DEPTH - 1))) begin
                sb_rd_r[DEPTH - 1] <= push_rd_s;
            end

            if (issue_s && !pop_eff_s) begin
                occ_r <= occ_r + 3'd1;
            end else if (!issue_s && pop_eff_s) begin
                occ_r <= occ_r - 3'd1;
            end

            if (pop_s && (occ_r == 3'd0)) begin
                err_r <= 1'b1;
            end
`ifdef HAZARD_CTRL_STAT_EN
            else if (pop_s && (M_REG_D != sb_rd_r[0])) begin
                err_r <= 1'b1;
            end
`endif
        end
    end

`ifdef HAZARD_CTRL_STAT_EN
    // Wrapping event counters: issues, HOLD cycles, accepted branches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STAT_ISSUE <= 32'd0;
            STAT_STALL <= 32'd0;
            STAT_FLUSH <= 32'd0;
        end else begin
            STAT_ISSUE <= STAT_ISSUE + {31'd0, issue_s};
            STAT_STALL <= STAT_STALL + {31'd0, hold_s};
            STAT_FLUSH <= STAT_FLUSH + {31'd0, br_acc_s};
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the RV32I core.
- Observes the decode stage outputs and keeps an in-order scoreboard of issued-but-not-retired destination registers. It stalls decode on read-after-write hazards.
- Freezes the whole pipeline on memory wait and squashes younger instructions for a taken branch.
- Sits beside decode; drives the decode/fetch hold, the execute bubble and the flush signals.

Parameters:
- DEPTH, 3, scoreboard entries (stages from issue to writeback commit); legal range 2..7.
- FLUSH_LEN, 2, cycles the FLUSH output is held after a taken branch; legal range 1..7.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- D_VALID  in  1  decode holds a valid instruction
- D_OPCODE  in  7  decoded opcode
- D_REG_D  in  5  rd
- D_REG_S1  in  5  rs1
- D_REG_S2  in  5  rs2
- MEM_BUSY  in  1  data/instruction memory wait
- BR_TAKEN  in  1  execute resolved a taken branch/jump this cycle
- M_VALID  in  1  writeback commit of the oldest in-flight instruction
- M_REG_D  in  5  rd being committed (checked only when STAT_EN is defined)
- HOLD  out  1  hold fetch and decode latches
- FREEZE  out  1  freeze all stages and gate regfile write
- BUBBLE  out  1  execute latch loads invalid
- ISSUE  out  1  decode instruction accepted into execute
- FLUSH  out  1  squash fetch/decode contents
- STATE  out  2  FSM state
- OCC  out  3  scoreboard occupancy
- ERR  out  1  sticky: commit with empty scoreboard

Behaviour:
- Reset: all state clears asynchronously: STATE=RUN, OCC=0, scoreboard empty, flush counter=0, ERR=0. While RST is high, outputs are forced to HOLD=0, FREEZE=0, BUBBLE=1, ISSUE=0, FLUSH=0.
- Operand usage by opcode:
  - 0110011: rs1, rs2, rd.
  - 0010011, 0000011, 1100111: rs1, rd.
  - 0100011, 1100011: rs1, rs2; no rd.
  - 0110111, 0010111, 1101111: rd only.
  - 0001111, 1110011, and any other opcode: nothing.
- Hazard: a used rs, nonzero, that equals any valid scoreboard rd, including an entry retiring this same cycle (regfile write lands at the edge). Register x0 never hazards.
- FSM states: RUN=0, INTERLOCK=1, FREEZE=2, FLUSH=3. Priority per cycle is MEM_BUSY > BR_TAKEN > FLUSH countdown > hazard/full > issue.
  - MEM_BUSY=1: next state FREEZE. FREEZE=1, HOLD=1, ISSUE=0. Scoreboard, counter and ERR are unchanged; M_VALID and BR_TAKEN are ignored (upstream holds them).
  - BR_TAKEN=1: next state FLUSH, counter loaded with FLUSH_LEN-1. ISSUE=0, BUBBLE=1, FLUSH=1 this cycle.
  - In FLUSH: FLUSH=1, ISSUE=0, BUBBLE=1, counter decrements. Return to RUN after the cycle in which counter==0; total FLUSH high = FLUSH_LEN cycles counting the BR_TAKEN cycle.
  - Hazard, or D_VALID with OCC==DEPTH and no commit this cycle: next state INTERLOCK. HOLD=1, BUBBLE=1, ISSUE=0.
  - Otherwise: next state RUN. ISSUE=D_VALID, BUBBLE=!D_VALID.
- HOLD/BUBBLE/ISSUE are combinational from inputs and registered scoreboard, zero latency. FLUSH is high in the BR_TAKEN cycle and while STATE==FLUSH. STATE and OCC are registered.
- Scoreboard is an in-order FIFO of {valid, rd}.
  - Push on ISSUE; rd is forced to 0 when the instruction writes no rd or rd=x0, so every issue gets an entry.
  - Pop on M_VALID && !MEM_BUSY.
  - Push and pop in the same cycle: OCC unchanged; the retiring entry is still compared that cycle.
  - Pop with OCC==0: ignored, ERR set until reset.
  - Push when full is impossible (interlocked) unless a pop occurs in the same cycle.
- In-flight entries are never squashed by a branch; only unissued decode/fetch content is flushed.
- Reset mid-flush or mid-interlock returns directly to RUN with an empty scoreboard.

Optional Feature:
- HAZARD_CTRL_STAT_EN defined:
  - Adds 32-bit wrapping output counters STAT_ISSUE, STAT_STALL (cycles with HOLD=1) and STAT_FLUSH (BR_TAKEN events accepted), all reset to 0.
  - ERR is also set when M_REG_D is not equal to the head entry rd.
- Undefined: no counter ports and no M_REG_D check; M_REG_D is unused.

Test Plan:
- Issue addi x5 (0010011, rd=5) then add x6,x5,x1 next cycle; no commit for 2 cycles -> HOLD=1, BUBBLE=1, STATE=1 for 2 cycles. The M_VALID for x5 holds for that cycle too; ISSUE=1 the following cycle; OCC returns to 1.
- lui x0 then addi x1,x0,1 back-to-back -> no stall, ISSUE=1 both cycles, OCC=2.
- BR_TAKEN=1 with D_VALID=1, FLUSH_LEN=2 -> ISSUE=0, FLUSH=1 for exactly 2 cycles, STATE=3 then 0; scoreboard entries unchanged.
- MEM_BUSY=1 for 3 cycles with M_VALID=1 and hazard present -> FREEZE=HOLD=1 for 3 cycles, OCC constant, STATE=2; the pop happens in the first cycle after MEM_BUSY drops.
- Fill to OCC=3 with D_VALID held and no M_VALID -> interlock. Then M_VALID together with a non-hazard issue -> ISSUE=1, OCC stays 3.
- M_VALID with OCC=0 -> ERR=1 and stays 1; assert RST asynchronously mid-FLUSH -> outputs immediately at reset values, ERR=0, OCC=0.
